// File: rtl/note_sequencer.sv
// note_sequencer: records up to 16 note codes into an external note RAM and
// plays them back, holding each note for TICKS_PER_STEP clocks with a
// one-cycle articulation gap between notes.
// Build option: define LOOP_PLAYBACK_EN to make playback repeat until it is
// stopped by a playback press or erased by clear_n.
module note_sequencer #(
  parameter int TICKS_PER_STEP = 25000000,
  parameter int DEPTH          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_n,
  input  logic       playback,
  input  logic       clear_n,
  input  logic [3:0] note_in,
  input  logic [3:0] mem_rdata,
  output logic [3:0] mem_addr,
  output logic       mem_wr,
  output logic [3:0] mem_wdata,
  output logic [3:0] note_out,
  output logic       tone_en,
  output logic       busy,
  output logic       full,
  output logic       play_done,
  output logic [4:0] count
);

  // Step counter only has to reach TICKS_PER_STEP-1.
  localparam int            CW          = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] STEP_RELOAD = CW'(TICKS_PER_STEP - 1);
  localparam logic [4:0]    DEPTH_C     = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY_FETCH = 2'd1,
    PLAY_HOLD  = 2'd2
  } state_t;

  state_t        state_r,     state_s;
  logic [4:0]    count_r,     count_s;
  logic [3:0]    mem_addr_r,  mem_addr_s;
  logic [3:0]    mem_wdata_r, mem_wdata_s;
  logic          mem_wr_r,    mem_wr_s;
  logic [3:0]    note_out_r,  note_out_s;
  logic          tone_en_r,   tone_en_s;
  logic          busy_r,      busy_s;
  logic          full_r,      full_s;
  logic          play_done_r, play_done_s;
  logic [CW-1:0] step_cnt_r,  step_cnt_s;
  logic          load_prev_r;
  logic          play_prev_r;

  logic          load_ev_s;
  logic          play_ev_s;
  logic          last_note_s;

  // A press is a 1 -> 0 transition between consecutive samples.
  assign load_ev_s   = load_prev_r & ~load_n;
  assign play_ev_s   = play_prev_r & ~playback;
  // Address points at the final stored note (only meaningful while count > 0).
  assign last_note_s = ({1'b0, mem_addr_r} == (count_r - 5'd1));

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_wr_s    = 1'b0;
    note_out_s  = note_out_r;
    tone_en_s   = tone_en_r;
    busy_s      = busy_r;
    play_done_s = 1'b0;
    step_cnt_s  = step_cnt_r;

    if (!clear_n) begin
      // Erase wins over everything, whatever the state.
      state_s   = IDLE;
      count_s   = 5'd0;
      tone_en_s = 1'b0;
      busy_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tone_en_s = 1'b0;
          busy_s    = 1'b0;
          if (load_ev_s) begin
            // Recording takes precedence over a simultaneous play press.
            if (count_r < DEPTH_C) begin
              mem_wr_s    = 1'b1;
              mem_addr_s  = count_r[3:0];
              mem_wdata_s = note_in;
              count_s     = count_r + 5'd1;
            end else begin
              mem_wr_s = 1'b0;
            end
          end else if (play_ev_s) begin
            if (count_r != 5'd0) begin
              state_s    = PLAY_FETCH;
              mem_addr_s = 4'd0;
              busy_s     = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = IDLE;
          end
        end

        PLAY_FETCH: begin
          if (play_ev_s) begin
            state_s   = IDLE;
            tone_en_s = 1'b0;
            busy_s    = 1'b0;
          end else begin
            // RAM data for mem_addr is valid now; capture it for the hold.
            state_s    = PLAY_HOLD;
            note_out_s = mem_rdata;
            tone_en_s  = 1'b1;
            step_cnt_s = STEP_RELOAD;
          end
        end

        PLAY_HOLD: begin
          if (play_ev_s) begin
            state_s   = IDLE;
            tone_en_s = 1'b0;
            busy_s    = 1'b0;
          end else if (step_cnt_r != {CW{1'b0}}) begin
            step_cnt_s = step_cnt_r - CW'(1);
          end else begin
            tone_en_s = 1'b0;
            if (!last_note_s) begin
              mem_addr_s = mem_addr_r + 4'd1;
              state_s    = PLAY_FETCH;
            end else begin
              play_done_s = 1'b1;
`ifdef LOOP_PLAYBACK_EN
              mem_addr_s  = 4'd0;
              state_s     = PLAY_FETCH;
`else
              state_s     = IDLE;
              busy_s      = 1'b0;
`endif
            end
          end
        end

        default: begin
          state_s   = IDLE;
          tone_en_s = 1'b0;
          busy_s    = 1'b0;
        end
      endcase
    end

    full_s = (count_s == DEPTH_C);
  end

  // State and output registers; reset clears the tone without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      mem_addr_r  <= 4'd0;
      mem_wdata_r <= 4'd0;
      mem_wr_r    <= 1'b0;
      note_out_r  <= 4'd0;
      tone_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      full_r      <= 1'b0;
      play_done_r <= 1'b0;
      step_cnt_r  <= {CW{1'b0}};
      load_prev_r <= 1'b1;
      play_prev_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wr_r    <= mem_wr_s;
      note_out_r  <= note_out_s;
      tone_en_r   <= tone_en_s;
      busy_r      <= busy_s;
      full_r      <= full_s;
      play_done_r <= play_done_s;
      step_cnt_r  <= step_cnt_s;
      load_prev_r <= load_n;
      play_prev_r <= playback;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wr    = mem_wr_r;
  assign mem_wdata = mem_wdata_r;
  assign note_out  = note_out_r;
  assign tone_en   = tone_en_r;
  assign busy      = busy_r;
  assign full      = full_r;
  assign play_done = play_done_r;
  assign count     = count_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with TICKS_PER_STEP=4.
// Stimulus pushes expected RAM writes, tones and end-of-playback pulses;
// a monitor pops and compares them as the DUT produces them.
module tb_note_sequencer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_n;
  logic       playback;
  logic       clear_n;
  logic [3:0] note_in;
  logic [3:0] mem_rdata;
  logic [3:0] mem_addr;
  logic       mem_wr;
  logic [3:0] mem_wdata;
  logic [3:0] note_out;
  logic       tone_en;
  logic       busy;
  logic       full;
  logic       play_done;
  logic [4:0] count;

  logic [3:0] ram [16];

  // kind: 0 = RAM write (a=addr, b=data), 1 = tone (a=note, b=length,
  // c=low cycles before it, -1 = don't care), 2 = play_done pulse
  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Note RAM model: write on clk, read data follows the address.
  always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  note_sequencer #(.TICKS_PER_STEP(TPS), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .load_n(load_n), .playback(playback),
    .clear_n(clear_n), .note_in(note_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .note_out(note_out), .tone_en(tone_en), .busy(busy), .full(full),
    .play_done(play_done), .count(count)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic void push(input int k, input int a, input int b, input int c);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(input string name, input int k, input int a, input int b, input int c);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event kind=%0d a=%0d b=%0d c=%0d, required no event",
               name, k, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || (e.c >= 0 && e.c != c)) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d a=%0d b=%0d c=%0d, required kind=%0d a=%0d b=%0d c=%0d",
                 name, k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // Monitor: samples on the falling edge and checks each observed event.
  initial begin
    logic tone_prev;
    int   tone_len;
    int   low_len;
    int   gap_at_rise;
    int   cur_note;
    tone_prev = 1'b0; tone_len = 0; low_len = 0; gap_at_rise = 0; cur_note = 0;
    forever begin
      @(negedge clk);
      if (mem_wr) pop_check("write", 0, int'(mem_addr), int'(mem_wdata), 0);
      if (!tone_en && tone_prev) pop_check("tone", 1, cur_note, tone_len, gap_at_rise);
      if (play_done) pop_check("play_done", 2, 0, 0, 0);
      if (tone_en) begin
        if (!tone_prev) begin
          cur_note    = int'(note_out);
          gap_at_rise = low_len;
          tone_len    = 0;
        end
        tone_len++;
        low_len = 0;
      end else begin
        low_len++;
      end
      tone_prev = tone_en;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  task automatic press_load(input int n);
    @(posedge clk); #2; note_in = 4'(n); load_n = 1'b0;
    @(posedge clk); #2; load_n = 1'b1;
  endtask

  task automatic press_play();
    @(posedge clk); #2; playback = 1'b0;
    @(posedge clk); #2; playback = 1'b1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2; clear_n = 1'b0;
    @(posedge clk); #2; clear_n = 1'b1;
  endtask

  // Returns on the falling edge where the n-th tone_en rise is seen.
  task automatic wait_rises(input int n);
    int   rises;
    logic prev;
    rises = 0;
    prev  = tone_en;
    for (int i = 0; i < 200 && rises < n; i++) begin
      @(negedge clk);
      if (tone_en && !prev) rises++;
      prev = tone_en;
    end
    if (rises < n) chk("tone_rise_timeout", rises, n);
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (play_done) seen = 1;
    end
    chk("play_done_seen", seen, 1);
  endtask

  initial begin
    reset = 1'b0; load_n = 1'b1; playback = 1'b1; clear_n = 1'b1; note_in = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tone_en", int'(tone_en), 0);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_play_done", int'(play_done), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_note_out", int'(note_out), 0);
    @(posedge clk); #2; reset = 1'b1;

    // Record 3,5,9
    push(0, 0, 3, 0); push(0, 1, 5, 0); push(0, 2, 9, 0);
    press_load(3); press_load(5); press_load(9);
    cycles(2);
    chk("load3_count", int'(count), 3);
    chk("load3_full", int'(full), 0);
    chk("load3_addr_hold", int'(mem_addr), 2);

    // Full playback
    push(1, 3, 4, -1); push(1, 5, 4, 1); push(1, 9, 4, 1); push(2, 0, 0, 0);
`ifdef LOOP_PLAYBACK_EN
    push(1, 3, 2, 1);
    press_play();
    wait_rises(4);
    press_play();
    @(negedge clk);
    chk("loop_stop_tone_en", int'(tone_en), 0);
    chk("loop_stop_busy", int'(busy), 0);
`else
    press_play();
    wait_done();
    chk("done_busy", int'(busy), 0);
    chk("done_tone_en", int'(tone_en), 0);
`endif
    cycles(3);
    chk("play_count_kept", int'(count), 3);

    // Abort during the second note: no play_done expected
    push(1, 3, 4, -1); push(1, 5, 2, 1);
    press_play();
    wait_rises(2);
    press_play();
    @(negedge clk);
    chk("abort_tone_en", int'(tone_en), 0);
    chk("abort_busy", int'(busy), 0);
    cycles(10);

    // Clear during the first note
    push(1, 3, 2, -1);
    press_play();
    wait_rises(1);
    pulse_clear();
    @(negedge clk);
    chk("clear_count", int'(count), 0);
    chk("clear_tone_en", int'(tone_en), 0);
    chk("clear_busy", int'(busy), 0);

    // Playback with nothing recorded does nothing
    press_play();
    cycles(8);
    chk("empty_play_busy", int'(busy), 0);

    // Load and playback pressed together: record wins
    push(0, 0, 7, 0);
    press_load(7);
    push(0, 1, 2, 0);
    @(posedge clk); #2; note_in = 4'd2; load_n = 1'b0; playback = 1'b0;
    @(posedge clk); #2; load_n = 1'b1; playback = 1'b1;
    cycles(2);
    chk("both_count", int'(count), 2);
    chk("both_busy", int'(busy), 0);

    // Seventeen presses after a clear: 16 writes, then full
    pulse_clear();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push(0, i, i & 15, 0);
      press_load(i);
      if (i == 14) begin
        @(negedge clk);
        chk("fill15_count", int'(count), 15);
        chk("fill15_full", int'(full), 0);
      end
    end
    cycles(2);
    chk("fill_count", int'(count), 16);
    chk("fill_full", int'(full), 1);

    // Asynchronous reset mid-hold drops the tone before the next clk edge
    push(1, 0, 1, -1);
    press_play();
    wait_rises(1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_tone_en", int'(tone_en), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(count), 0);
    @(posedge clk); #2; reset = 1'b1;
    cycles(4);
    chk("post_rst_full", int'(full), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICKS_PER_STEP, default 25000000, clk cycles each played note is held (0.5 s at 50 MHz); legal range 2..2^25.
REQ-002 Parameter DEPTH, fixed 16, number of note slots in the external note RAM.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_n  input  1  active-low record request; each press records one note.
REQ-006 playback  input  1  active-low play/stop request.
REQ-007 clear_n  input  1  active-low, level-sensitive erase of the recording.
REQ-008 note_in  input  4  note code to record.
REQ-009 mem_rdata  input  4  note RAM read data, valid one cycle after mem_addr.
REQ-010 mem_addr  output  4  note RAM address.
REQ-011 mem_wr / mem_wdata  output  1 / 4  note RAM write strobe / write data.
REQ-012 note_out  output  4  note code to the tone generator.
REQ-013 tone_en  output  1  tone generator enable.
REQ-014 busy / full / play_done  output  1 / 1 / 1  playing / 16 notes stored / one-cycle end-of-playback pulse.
REQ-015 count  output  5  number of stored notes, 0..16.

Function
REQ-016 load_n, playback and clear_n are already synchronous to clk; an event on load_n or playback is the first rising edge where the input samples 0 after having sampled 1 (previous-value registers).
REQ-017 States: IDLE, PLAY_FETCH, PLAY_HOLD; all outputs are registered.
REQ-018 IDLE + load event + count<16: mem_wr=1, mem_addr=count, mem_wdata=note_in for exactly the one cycle after the event; count increments on that same edge.
REQ-019 Load event with count==16: ignored, no write; full=1 whenever count==16.
REQ-020 IDLE + playback event + count>0: go to PLAY_FETCH with mem_addr=0 and busy=1; playback event with count==0 is ignored.
REQ-021 Load and playback events on the same edge in IDLE: the record wins and playback is dropped.
REQ-022 PLAY_FETCH lasts one cycle with tone_en=0, then PLAY_HOLD; on entry to PLAY_HOLD, note_out is latched from mem_rdata.
REQ-023 PLAY_HOLD lasts exactly TICKS_PER_STEP cycles with tone_en=1; a down-counter is reloaded on each entry.
REQ-024 At the end of PLAY_HOLD with mem_addr<count-1: mem_addr increments and the state returns to PLAY_FETCH, giving a one-cycle articulation gap.
REQ-025 At the end of PLAY_HOLD with mem_addr==count-1: go to IDLE; play_done=1 for one cycle, and tone_en=0 and busy=0 on the same edge.
REQ-026 During PLAY_*, load events are ignored.
REQ-027 A playback event during PLAY_* aborts to IDLE; tone_en and busy are 0 on the next edge and play_done is not pulsed.
REQ-028 clear_n==0 in any state: state becomes IDLE, count=0, and tone_en, busy and mem_wr are 0 on the next edge; clear has priority over every other event.
REQ-029 mem_addr holds its last value in IDLE, except during a write cycle.

Reset
REQ-030 On reset==0, asynchronously: state=IDLE, count=0, mem_addr=0, mem_wdata=0, note_out=0, mem_wr=0, tone_en=0, busy=0, full=0, play_done=0, step counter=0, previous-value registers=1.
REQ-031 Reset asserted mid-playback stops the tone immediately, without waiting for a clock edge.

Configuration
REQ-032 Macro LOOP_PLAYBACK_EN: when defined, the last-note case of REQ-025 instead sets mem_addr=0 and returns to PLAY_FETCH; playback repeats until a playback event (REQ-027) or clear, and play_done pulses once per completed pass.
REQ-033 Without LOOP_PLAYBACK_EN, playback runs once per REQ-025.

Verification (TICKS_PER_STEP=4)
REQ-034 Reset, then three load presses with note_in=3,5,9 -> writes at addr 0,1,2 with data 3,5,9; count=3; full=0.
REQ-035 Playback with count=3, RAM={3,5,9} -> note_out 3,5,9, each with tone_en high for 4 cycles, one-cycle gaps between notes, play_done pulse, busy=0; with LOOP_PLAYBACK_EN the sequence repeats.
REQ-036 Seventeen load presses -> 16 writes; count=16; full=1; the 17th press produces no mem_wr.
REQ-037 Playback press during the second note -> tone_en=0 and busy=0 on the next edge; no play_done pulse.
REQ-038 Load and playback falling together in IDLE -> one write, count+1, busy stays 0; playback with count=0 -> no response.
REQ-039 clear_n low mid-playback -> IDLE, count=0; async reset mid-hold -> tone_en=0 before the next clk edge.
